flag_branch_unit: RTL and testbench

Sequential control block at the flag and next-PC end of the single-cycle datapath. It registers the N/V/Z flags produced by the ALU and feeds them back to the ALU as `FLAG_in`. It evaluates branch condition codes against the registered flags and owns the PC register. It also runs a RUN/HALTED state machine for the HLT instruction.

---
 rtl/flag_branch_if.sv | 32 +++
 rtl/flag_branch_unit.sv | 89 ++++++++
 tb/tb_flag_branch_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/flag_branch_if.sv
// Bundles the datapath-side signals of flag_branch_unit: ALU flags, branch
// decode, PC outputs and halt status. Clock and reset stay outside.
`default_nettype none

interface flag_branch_if;
    logic [2:0]  FLAG;
    logic [2:0]  flag_we;
    logic        stall;
    logic        branch;
    logic        branch_reg;
    logic [2:0]  ccc;
    logic [8:0]  imm9;
    logic [15:0] rs_data;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic [2:0]  FLAG_out;
    logic        taken;
    logic        halted;

    modport master (
        output FLAG, flag_we, stall, branch, branch_reg, ccc, imm9, rs_data, halt,
        input  pc, pc_plus2, FLAG_out, taken, halted
    );

    modport slave (
        input  FLAG, flag_we, stall, branch, branch_reg, ccc, imm9, rs_data, halt,
        output pc, pc_plus2, FLAG_out, taken, halted
    );
endinterface

`default_nettype wire

// File: rtl/flag_branch_unit.sv
// Flag register, branch condition evaluation, PC register and RUN/HALTED
// control for the single-cycle datapath.
`default_nettype none

module flag_branch_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    flag_branch_if.slave  fb_if
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [15:0] pc_q, pc_d;
    logic [2:0]  flag_q, flag_d;
    logic [0:0]  state_q, state_d;

    logic [15:0] pc_plus2_w;
    logic [15:0] b_offset_w;
    logic [15:0] target_w;
    logic        cond_w;
    logic        taken_w;
    logic        flag_n_w, flag_v_w, flag_z_w;

    assign flag_n_w = flag_q[0];
    assign flag_v_w = flag_q[1];
    assign flag_z_w = flag_q[2];

    assign pc_plus2_w = pc_q + 16'd2;
    // sext16(imm9) << 1 folded into a single concatenation
    assign b_offset_w = {{6{fb_if.imm9[8]}}, fb_if.imm9, 1'b0};
    assign target_w   = fb_if.branch_reg ? fb_if.rs_data : (pc_plus2_w + b_offset_w);

    always_comb begin
        cond_w = 1'b1;
        case (fb_if.ccc)
            3'b000:  cond_w = ~flag_z_w;
            3'b001:  cond_w = flag_z_w;
            3'b010:  cond_w = ~flag_z_w & ~flag_n_w;
            3'b011:  cond_w = flag_n_w;
            3'b100:  cond_w = flag_z_w | (~flag_z_w & ~flag_n_w);
            3'b101:  cond_w = flag_n_w | flag_z_w;
            3'b110:  cond_w = flag_v_w;
            default: cond_w = 1'b1;
        endcase
    end

    // Reset masks taken so an "always" code cannot leak out while rst_n is low
    assign taken_w = rst_n & (fb_if.branch | fb_if.branch_reg) & cond_w & (state_q == ST_RUN);

    always_comb begin
        pc_d    = pc_q;
        flag_d  = flag_q;
        state_d = state_q;
        if ((state_q == ST_RUN) && !fb_if.stall) begin
            flag_d = (flag_q & ~fb_if.flag_we) | (fb_if.FLAG & fb_if.flag_we);
            if (fb_if.halt) begin
                state_d = ST_HALTED;
            end else if (taken_w) begin
                pc_d = target_w;
            end else begin
                pc_d = pc_plus2_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= PC_RESET;
            flag_q  <= 3'b000;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            flag_q  <= flag_d;
            state_q <= state_d;
        end
    end

    assign fb_if.pc       = pc_q;
    assign fb_if.pc_plus2 = pc_plus2_w;
    assign fb_if.FLAG_out = flag_q;
    assign fb_if.taken    = taken_w;
    assign fb_if.halted   = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: a reference model pushes expected
// register state per cycle, popped and compared after each clock edge.
`default_nettype none

module tb_flag_branch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [2:0]  fl;
        logic        h;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    exp_t        sb_q[$];
    logic [15:0] m_pc;
    logic [2:0]  m_fl;
    logic        m_h;

    flag_branch_if bus();

    flag_branch_unit #(.PC_RESET(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fb_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic cond_m(input logic [2:0] c, input logic [2:0] f);
        logic n, v, z;
        n = f[0]; v = f[1]; z = f[2];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic step(input logic st, input logic br, input logic brr, input logic [2:0] c,
                        input logic [8:0] imm, input logic [15:0] rs, input logic hl,
                        input logic [2:0] we, input logic [2:0] fl);
        logic        tk;
        logic [15:0] p2, tgt;
        logic [15:0] off;
        exp_t        e, g;
        bus.stall = st; bus.branch = br; bus.branch_reg = brr; bus.ccc = c;
        bus.imm9 = imm; bus.rs_data = rs; bus.halt = hl; bus.flag_we = we; bus.FLAG = fl;
        #1;
        p2  = m_pc + 16'd2;
        off = 16'($signed(imm)) * 16'd2;
        tgt = brr ? rs : (p2 + off);
        tk  = (br | brr) && cond_m(c, m_fl) && !m_h;
        chk("taken", {31'd0, bus.taken}, {31'd0, tk});
        chk("pc_plus2", {16'd0, bus.pc_plus2}, {16'd0, p2});
        if (!m_h && !st) begin
            for (int i = 0; i < 3; i++) if (we[i]) m_fl[i] = fl[i];
            if (hl) m_h = 1'b1;
            else if (tk) m_pc = tgt;
            else m_pc = p2;
        end
        sb_q.push_back('{pc: m_pc, fl: m_fl, h: m_h});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            g = '{pc: bus.pc, fl: bus.FLAG_out, h: bus.halted};
            chk("pc", {16'd0, g.pc}, {16'd0, e.pc});
            chk("flags", {29'd0, g.fl}, {29'd0, e.fl});
            chk("halted", {31'd0, g.h}, {31'd0, e.h});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 1'b0, 3'b000, 3'b000);
    endtask

    task automatic jump(input logic [15:0] a);
        step(1'b0, 1'b0, 1'b1, 3'd7, 9'd0, a, 1'b0, 3'b000, 3'b000);
    endtask

    // Async reset pulse taken between edges, with an always-taken branch applied
    task automatic rst_pulse();
        bus.branch = 1'b1; bus.ccc = 3'd7; bus.halt = 1'b0; bus.stall = 1'b0;
        rst_n = 1'b0;
        #1;
        m_pc = 16'h0000; m_fl = 3'b000; m_h = 1'b0;
        chk("rst_pc", {16'd0, bus.pc}, 32'h0);
        chk("rst_flags", {29'd0, bus.FLAG_out}, 32'h0);
        chk("rst_halted", {31'd0, bus.halted}, 32'h0);
        chk("rst_taken", {31'd0, bus.taken}, 32'h0);
        #1;
        rst_n = 1'b1;
        bus.branch = 1'b0;
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        m_pc = 16'h0000; m_fl = 3'b000; m_h = 1'b0;
        bus.FLAG = 3'b000; bus.flag_we = 3'b000; bus.stall = 1'b0; bus.branch = 1'b0;
        bus.branch_reg = 1'b0; bus.ccc = 3'd0; bus.imm9 = 9'd0; bus.rs_data = 16'd0; bus.halt = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("init_pc", {16'd0, bus.pc}, 32'h0);
        chk("init_halted", {31'd0, bus.halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        idle(); chk("tp_pc2", {16'd0, bus.pc}, 32'h0002);
        idle(); idle(); chk("tp_pc6", {16'd0, bus.pc}, 32'h0006);

        // Z set, then B EQ -2 from 0x0010
        jump(16'h000E);
        step(1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 1'b0, 3'b111, 3'b100);
        step(1'b0, 1'b1, 1'b0, 3'd1, 9'h1FE, 16'd0, 1'b0, 3'b000, 3'b000);
        chk("tp_eq_taken", {16'd0, bus.pc}, 32'h000E);
        idle();
        step(1'b0, 1'b1, 1'b0, 3'd0, 9'h1FE, 16'd0, 1'b0, 3'b000, 3'b000);
        chk("tp_ne_not", {16'd0, bus.pc}, 32'h0012);

        // Same-cycle flag write does not affect branch
        step(1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 1'b0, 3'b111, 3'b000);
        step(1'b0, 1'b1, 1'b0, 3'd1, 9'h010, 16'd0, 1'b0, 3'b111, 3'b100);
        chk("tp_hazard_pc", {16'd0, bus.pc}, 32'h0016);
        chk("tp_hazard_fl", {29'd0, bus.FLAG_out}, 32'h4);

        // Partial flag write then V / N branches
        step(1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 1'b0, 3'b111, 3'b010);
        step(1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 1'b0, 3'b101, 3'b001);
        chk("tp_partial", {29'd0, bus.FLAG_out}, 32'h3);
        step(1'b0, 1'b1, 1'b1, 3'd6, 9'h0F0, 16'hBEEF, 1'b0, 3'b000, 3'b000);
        chk("tp_ovfl", {16'd0, bus.pc}, 32'hBEEF);
        step(1'b0, 1'b0, 1'b1, 3'd3, 9'd0, 16'h1234, 1'b0, 3'b000, 3'b000);
        chk("tp_lt", {16'd0, bus.pc}, 32'h1234);

        // Stall, then halt at 0x0020
        step(1'b1, 1'b0, 1'b1, 3'd7, 9'd0, 16'h5555, 1'b0, 3'b111, 3'b111);
        chk("tp_stall_pc", {16'd0, bus.pc}, 32'h1234);
        jump(16'h0020);
        step(1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 1'b1, 3'b000, 3'b000);
        chk("tp_halt", {31'd0, bus.halted}, 32'h1);
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b1, 1'b1, 3'd7, 9'h033, 16'h7777, 1'b0, 3'b111, 3'b111);
        chk("tp_halt_pc", {16'd0, bus.pc}, 32'h0020);
        rst_pulse();

        // Wrap cases
        jump(16'hFFFE);
        idle(); chk("tp_wrap", {16'd0, bus.pc}, 32'h0000);
        step(1'b0, 1'b1, 1'b0, 3'd7, 9'h100, 16'd0, 1'b0, 3'b000, 3'b000);
        chk("tp_neg_wrap", {16'd0, bus.pc}, 32'hFE02);

        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 3'($urandom),
                 9'($urandom), 16'($urandom), ($urandom_range(0, 29) == 0),
                 3'($urandom), 3'($urandom));
            if (m_h && ($urandom_range(0, 3) == 0)) rst_pulse();
        end

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
